// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: decodes op/funct into per-cycle datapath
// selects, write enables and the ALU control code, with a memory ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4, wait for mem_ready
// DECODE   | read registers, precompute branch target, dispatch on op
// MEMADR   | ALUOut <= A + sign-extended offset (lw/sw)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | rt <= memory data
// MEMWRITE | write B to data memory at ALUOut, wait for mem_ready
// EXECUTE  | R-type ALU operation selected by funct
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A and B, PC <= branch target if equal
// ADDIEXEC | ALUOut <= A + sign-extended immediate
// ADDIWB   | rt <= ALUOut
// JUMP     | PC <= jump target
module multicycle_control_unit #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   rdy;
    logic   ir_write_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;
    logic   illegal_raw;
    logic   pc_write;
    logic   branch;

    // With waiting disabled every memory access completes in its first cycle.
    assign rdy = mem_ready | !MEM_WAIT_EN;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = FETCH;
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = 3'b000;
        PCSrc         = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = rdy;
                pc_write     = rdy;
                state_d      = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                IorD    = 1'b1;
                state_d = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                // Write strobe only in the accepting cycle: one pulse per sw.
                IorD          = 1'b1;
                mem_write_raw = rdy;
                state_d       = rdy ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                state_d = ALUWB;
                case (funct)
                    6'b100000: ALUControl = 3'b000;
                    6'b100010: ALUControl = 3'b001;
                    6'b100100: ALUControl = 3'b010;
                    6'b100110: ALUControl = 3'b011;
                    6'b101010: ALUControl = 3'b101;
                    default:   illegal_raw = 1'b1;
                endcase
            end
            ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b001;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are masked while reset is asserted so an abandoned instruction
    // cannot write anything in the reset cycle.
    assign IRWrite    = ir_write_raw & rst_n;
    assign MemWrite   = mem_write_raw & rst_n;
    assign RegWrite   = reg_write_raw & rst_n;
    assign illegal_op = illegal_raw & rst_n;
    assign PCEn       = (pc_write | (branch & zero)) & rst_n;
    assign state      = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential control FSM for the multicycle MIPS-subset datapath; sits directly upstream of the ALU.
- Decodes the latched instruction's op/funct and drives the per-cycle datapath selects, the write enables and the 3-bit ALUControl code.
- Consumes the ALU zero flag for beq and a memory ready handshake for fetch/load/store.

Parameters:
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
op  input  6  instruction[31:26] from instruction register
funct  input  6  instruction[5:0] from instruction register
zero  input  1  ALU zero flag (result == 0), combinational from ALU
mem_ready  input  1  memory has completed the current access this cycle
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load enable
RegDst  output  1  write register: 0 = rt, 1 = rd
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = memory data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
ALUControl  output  3  000 add, 001 sub, 010 and, 011 xor, 101 slt
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load enable = PCWrite | (Branch & zero)
illegal_op  output  1  one-cycle pulse on unsupported opcode
state  output  4  current state encoding, debug/verification

Behaviour:
- Outputs are Moore-decoded from state. Exceptions: PCEn uses zero; IRWrite/PCWrite/MemWrite are qualified by mem_ready where noted.
- Every output not listed for a state is 0. ALUControl defaults to 000.
- State encoding (4 bits):
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Codes 12-15 are unreachable and go to FETCH on the next edge.
- Reset: rst_n=0 at a rising edge -> state=FETCH.
  - While rst_n=0, PCEn, IRWrite, MemWrite, RegWrite and illegal_op are forced 0 combinationally.
  - Reset mid-instruction abandons it; no partial writes after the reset edge.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=000, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=000. Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - any other op -> FETCH with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=000. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: IorD=1. Stay until mem_ready=1, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE: IorD=1, MemWrite=mem_ready. Stay until mem_ready=1, then -> FETCH. Exactly one MemWrite pulse per sw.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct -> ALUWB.
  - 100000 add -> 000
  - 100010 sub -> 001
  - 100100 and -> 010
  - 100110 xor -> 011
  - 101010 slt -> 101
  - other funct: ALUControl=000 and illegal_op=1 pulse; still proceeds to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=001, PCSrc=01, Branch=1; PCEn=zero -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=000 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 (with mem_ready=1 throughout). Each extra mem_ready=0 cycle adds one.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- MEM_WAIT_EN=0: FETCH, MEMREAD and MEMWRITE each last exactly one cycle.

Test Plan:
- Reset then mem_ready=1, op=100011: state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; IRWrite=1 only in state 0.
- R-type, op=000000 with funct in {100000, 100010, 100100, 100110, 101010}: ALUControl in EXECUTE = 000, 001, 010, 011, 101 respectively. RegDst=1, RegWrite=1 in ALUWB.
- beq (op=000100) with zero=1 -> PCEn=1, PCSrc=01 in BRANCH. Repeat with zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE: state stays 5, MemWrite=0 during the wait. MemWrite=1 in exactly the cycle mem_ready=1, then FETCH.
- op=111111 in DECODE -> illegal_op=1 for one cycle, next state FETCH, no RegWrite/MemWrite asserted.
- rst_n=0 for one edge while in MEMWB: RegWrite=0 that cycle, state=FETCH after the edge, all enables 0.
